// File: rtl/rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// rf_wb_scheduler
//
// Writeback scheduler and hazard scoreboard for the RV32I register file.
// The ALU and the LSU share the register file's single write port through a
// valid/ready handshake. The scheduler registers each accepted result into
// the write port, and it keeps a 32-bit scoreboard of pending destination
// registers. The issue stage is stalled on RAW and WAW hazards.
//
// Build option:
//   RF_WB_RR_EN  defined   -> round-robin arbitration between ALU and LSU
//                             when both request in the same cycle
//                undefined -> fixed priority, LSU over ALU (no pointer state)
//
// Ports:
//   clk, rst (async, active-low)
//   iss_valid/iss_we/iss_rd/iss_rs1/iss_rs2  issue-stage instruction
//   iss_stall                                hazard stall (combinational)
//   alu_valid/alu_rd/alu_data, alu_ready     ALU writeback request/grant
//   lsu_valid/lsu_rd/lsu_data, lsu_ready     LSU writeback request/grant
//   rf_en/rf_rd/rf_wdata                     registered register-file write
//   busy                                     scoreboard (bit r = xr pending)
// ---------------------------------------------------------------------------
module rf_wb_scheduler #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic            iss_we,
   input  logic [4:0]      iss_rd,
   input  logic [4:0]      iss_rs1,
   input  logic [4:0]      iss_rs2,
   output logic            iss_stall,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            lsu_ready,
   output logic            rf_en,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     busy
);

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   logic both_valid;
   logic lsu_wins;   // which source takes a conflict cycle

   assign both_valid = alu_valid & lsu_valid;

`ifdef RF_WB_RR_EN
   // Holds "LSU has priority at the next conflict". Reset favours the LSU;
   // after every conflict the loser becomes the favoured source.
   logic rr_lsu_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_lsu_q <= 1'b1;
      end else if (both_valid) begin
         rr_lsu_q <= ~rr_lsu_q;
      end
   end

   assign lsu_wins = rr_lsu_q;
`else
   assign lsu_wins = 1'b1;
`endif

   // Grants depend only on the request inputs and arbiter state, never on
   // the issue-stage inputs.
   assign lsu_ready = lsu_valid & (~alu_valid | lsu_wins);
   assign alu_ready = alu_valid & ~(lsu_valid & lsu_wins);

   // ------------------------------------------------------------------------
   // Write port
   // ------------------------------------------------------------------------
   logic [4:0]      xfer_rd;
   logic [XLEN-1:0] xfer_data;
   logic            xfer_wr;

   assign xfer_rd   = lsu_ready ? lsu_rd   : alu_rd;
   assign xfer_data = lsu_ready ? lsu_data : alu_data;
   // A transfer to x0 completes its handshake but never reaches the port.
   assign xfer_wr   = (lsu_ready | alu_ready) & (xfer_rd != 5'd0);

   logic            rf_en_q;
   logic [4:0]      rf_rd_q;
   logic [XLEN-1:0] rf_wdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_en_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= '0;
      end else begin
         rf_en_q <= xfer_wr;
         // Address and data hold their last value when nothing is written.
         if (xfer_wr) begin
            rf_rd_q    <= xfer_rd;
            rf_wdata_q <= xfer_data;
         end
      end
   end

   assign rf_en    = rf_en_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;

   // ------------------------------------------------------------------------
   // Scoreboard and hazard detection
   // ------------------------------------------------------------------------
   logic [31:0] busy_q;
   logic [31:0] busy_d;
   logic        raw1;
   logic        raw2;
   logic        waw;
   logic        iss_set;

   assign raw1 = (iss_rs1 != 5'd0) & busy_q[iss_rs1];
   assign raw2 = (iss_rs2 != 5'd0) & busy_q[iss_rs2];
   assign waw  = iss_we & (iss_rd != 5'd0) & busy_q[iss_rd];

   assign iss_stall = iss_valid & (raw1 | raw2 | waw);
   assign iss_set   = iss_valid & ~iss_stall & iss_we & (iss_rd != 5'd0);

   // The bit clears at the same edge the register file captures the data,
   // so a dependent instruction issues on the following cycle without any
   // forwarding. A reservation made on that same edge takes precedence.
   assign busy_d[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_busy
         assign busy_d[gi] = (iss_set & (iss_rd == 5'(gi)))
                           | (busy_q[gi] & ~(rf_en_q & (rf_rd_q == 5'(gi))));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_scheduler
//
// Directed bench for rf_wb_scheduler. Each granted writeback is pushed onto a
// scoreboard queue tagged with the cycle its register-file write must appear
// in; a negedge monitor pops and compares entries, and checks rf_en=0 on all
// other cycles. Conflict expectations follow RF_WB_RR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_rf_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        iss_valid = 1'b0;
   logic        iss_we = 1'b0;
   logic [4:0]  iss_rd = 5'd0;
   logic [4:0]  iss_rs1 = 5'd0;
   logic [4:0]  iss_rs2 = 5'd0;
   logic        iss_stall;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = 5'd0;
   logic [31:0] alu_data = 32'd0;
   logic        alu_ready;
   logic        lsu_valid = 1'b0;
   logic [4:0]  lsu_rd = 5'd0;
   logic [31:0] lsu_data = 32'd0;
   logic        lsu_ready;
   logic        rf_en;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [31:0] busy;

   rf_wb_scheduler #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_we    (iss_we),
      .iss_rd    (iss_rd),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_stall (iss_stall),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .lsu_valid (lsu_valid),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .lsu_ready (lsu_ready),
      .rf_en     (rf_en),
      .rf_rd     (rf_rd),
      .rf_wdata  (rf_wdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [4:0]  last_rd = 5'd0;
   logic [31:0] last_data = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expect a register-file write on the next cycle (nothing for x0).
   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      if (rd != 5'd0) begin
         q.push_back('{cyc + 1, rd, data});
         last_rd   = rd;
         last_data = data;
         $display("xfer: cycle %0d rd=x%0d data=%h", cyc, rd, data);
      end else begin
         $display("xfer: cycle %0d rd=x0 discarded", cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Write-port monitor: one comparison set every cycle.
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
         mon_e = q.pop_front();
         chk("wb_en", 32'(rf_en), 32'd1);
         chk("wb_rd", 32'(rf_rd), 32'(mon_e.rd));
         chk("wb_data", rf_wdata, mon_e.data);
         $display("write: cycle %0d rf_rd=x%0d rf_wdata=%h", cyc, rf_rd, rf_wdata);
      end else begin
         chk("idle_en", 32'(rf_en), 32'd0);
      end
   end

   logic lsu_pri;
   int   a_idx;
   int   l_idx;
   logic exp_l;

   initial begin
      // ---------------- reset with both requests high ----------------
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444_4444;
      lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h6666_6666;
      repeat (3) tick;
      #1;
      chk("rst_busy", busy, 32'd0);
      chk("rst_rf_en", 32'(rf_en), 32'd0);
      chk("rst_rf_rd", 32'(rf_rd), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
      chk("rst_alu_ready", 32'(alu_ready), 32'd0);
      tick;
      alu_valid = 1'b0; lsu_valid = 1'b0; rst = 1'b1;
      #1;
      chk("idle_alu_ready", 32'(alu_ready), 32'd0);
      chk("idle_lsu_ready", 32'(lsu_ready), 32'd0);
      chk("idle_stall", 32'(iss_stall), 32'd0);
      repeat (2) tick;

      // ---------------- issue x5 and ALU writeback ----------------
      iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
      #1;
      chk("iss5_stall", 32'(iss_stall), 32'd0);
      tick;
      iss_valid = 1'b0; iss_we = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      #1;
      chk("busy5_set", busy, 32'h0000_0020);
      chk("alu5_ready", 32'(alu_ready), 32'd1);
      chk("alu5_lsu_ready", 32'(lsu_ready), 32'd0);
      push(alu_rd, alu_data);
      tick;
      alu_valid = 1'b0;
      #1;
      chk("busy5_during_commit", busy, 32'h0000_0020);
      tick;
      chk("busy5_clear", busy, 32'd0);

      // ---------------- RAW stall on x7 ----------------
      iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
      #1;
      chk("iss7_stall", 32'(iss_stall), 32'd0);
      tick;
      iss_we = 1'b0; iss_rd = 5'd0; iss_rs2 = 5'd7;
      #1;
      chk("busy7_set", busy, 32'h0000_0080);
      chk("raw2_stall_a", 32'(iss_stall), 32'd1);
      tick;
      chk("raw2_stall_b", 32'(iss_stall), 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777;
      #1;
      chk("raw2_stall_c", 32'(iss_stall), 32'd1);
      chk("alu7_ready", 32'(alu_ready), 32'd1);
      push(alu_rd, alu_data);
      tick;
      alu_valid = 1'b0;
      #1;
      chk("raw2_stall_commit", 32'(iss_stall), 32'd1);
      tick;
      chk("raw2_released", 32'(iss_stall), 32'd0);
      // re-reserve x7 for the x0-source and WAW checks
      iss_we = 1'b1; iss_rd = 5'd7; iss_rs2 = 5'd0;
      #1;
      chk("iss7b_stall", 32'(iss_stall), 32'd0);
      tick;
      iss_we = 1'b0; iss_rd = 5'd0;
      #1;
      chk("x0_src_no_stall", 32'(iss_stall), 32'd0);
      iss_we = 1'b1; iss_rd = 5'd7;
      #1;
      chk("waw_stall", 32'(iss_stall), 32'd1);
      iss_we = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd7;
      #1;
      chk("raw1_stall", 32'(iss_stall), 32'd1);
      iss_valid = 1'b0;
      #1;
      chk("novalid_no_stall", 32'(iss_stall), 32'd0);
      iss_rs1 = 5'd0;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7070_7070;
      #1;
      chk("lsu7_ready", 32'(lsu_ready), 32'd1);
      push(lsu_rd, lsu_data);
      tick;
      lsu_valid = 1'b0;
      tick;
      chk("busy7_clear", busy, 32'd0);

      // ---------------- conflict: both valid for 4 cycles ----------------
      lsu_pri = 1'b1;
      a_idx = 0;
      l_idx = 0;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) tick;
         alu_valid = 1'b1; alu_rd = 5'(10 + a_idx); alu_data = 32'hA000_0000 + 32'(a_idx);
         lsu_valid = 1'b1; lsu_rd = 5'(20 + l_idx); lsu_data = 32'hB000_0000 + 32'(l_idx);
         #1;
         exp_l = lsu_pri;
         chk("conf_lsu_ready", 32'(lsu_ready), 32'(exp_l));
         chk("conf_alu_ready", 32'(alu_ready), 32'(!exp_l));
         if (exp_l) begin
            push(lsu_rd, lsu_data);
            l_idx++;
         end else begin
            push(alu_rd, alu_data);
            a_idx++;
         end
`ifdef RF_WB_RR_EN
         lsu_pri = !lsu_pri;
`endif
      end
      tick;
      lsu_valid = 1'b0;
      alu_rd = 5'(10 + a_idx); alu_data = 32'hA000_0000 + 32'(a_idx);
      #1;
      chk("alu_after_lsu_drop", 32'(alu_ready), 32'd1);
      push(alu_rd, alu_data);
      tick;
      alu_valid = 1'b0;

      // ---------------- LSU write to x0 ----------------
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_1234;
      #1;
      chk("x0_lsu_ready", 32'(lsu_ready), 32'd1);
      push(lsu_rd, lsu_data);
      tick;
      lsu_valid = 1'b0;
      #1;
      chk("x0_rd_hold", 32'(rf_rd), 32'(last_rd));
      chk("x0_data_hold", rf_wdata, last_data);
      chk("x0_busy", busy, 32'd0);

      // ---------------- same-edge set and clear on x3 ----------------
      tick;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_0003;
      #1;
      chk("alu3_ready", 32'(alu_ready), 32'd1);
      push(alu_rd, alu_data);
      tick;
      alu_valid = 1'b0;
      iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd3;
      #1;
      chk("iss3_stall", 32'(iss_stall), 32'd0);
      tick;
      iss_valid = 1'b0; iss_we = 1'b0; iss_rd = 5'd0;
      #1;
      chk("busy3_set_wins", busy, 32'h0000_0008);

      // ---------------- reset mid-operation ----------------
      tick;
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999_9999;
      #1;
      chk("lsu9_ready", 32'(lsu_ready), 32'd1);
      #1;
      rst = 1'b0;
      tick;
      lsu_valid = 1'b0;
      #1;
      chk("midrst_busy", busy, 32'd0);
      chk("midrst_rf_rd", 32'(rf_rd), 32'd0);
      chk("midrst_rf_wdata", rf_wdata, 32'd0);
      tick;
      rst = 1'b1;
      repeat (3) tick;
      chk("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
